// File: rtl/watermark_pkg.sv
// Shared state encoding and constants for the difference-expansion watermark embedder.
package watermark_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CALC,
        WR0,
        WR1,
        NEXT,
        DONE
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_HEIGHT = 8;
    localparam int NUM_PAIRS  = DEF_WIDTH * DEF_HEIGHT / 2;

    localparam logic [9:0] PIX_MAX = 10'd255;

    function automatic int num_pairs(input int width, input int height);
        return width * height / 2;
    endfunction

endpackage

// File: rtl/de_pair_calc.sv
// Combinational difference-expansion of one pixel pair; shared by embed and extract paths.
module de_pair_calc
    import watermark_pkg::*;
(
    input  logic [7:0] p0,
    input  logic [7:0] p1,
    input  logic       b,
    output logic [7:0] new_p0,
    output logic [7:0] new_p1,
    output logic       embeddable
);

    logic [9:0] a0, a1, hi, lo, d, avg, h, half, up;
    logic [7:0] dn;
    logic       p0_is_hi;

    always_comb begin
        a0       = {2'b00, p0};
        a1       = {2'b00, p1};
        p0_is_hi = (a0 >= a1);
        hi       = p0_is_hi ? a0 : a1;
        lo       = p0_is_hi ? a1 : a0;
        d        = hi - lo;
        avg      = (a0 + a1) >> 1;
        h        = {d[8:0], 1'b0} + {9'b0, b};
        half     = h >> 1;
        up       = avg + ((h + 10'd1) >> 1);
        // dn only matters when half <= avg, so the low byte never wraps in that case
        dn       = avg[7:0] - half[7:0];

        embeddable = (d != 10'd0) && (up <= PIX_MAX) && (half <= avg);
        new_p0     = p0_is_hi ? up[7:0] : dn;
        new_p1     = p0_is_hi ? dn : up[7:0];
    end

endmodule

// File: rtl/watermark_embed_ctrl.sv
// Walks the frame in horizontal pixel pairs, embedding payload bits by difference expansion.
module watermark_embed_ctrl
    import watermark_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int PAYLOAD_BITS = 8,
    parameter int ADDR_W       = 6,
    localparam int CNT_W       = $clog2(PAYLOAD_BITS + 1)
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    start,
    input  logic [PAYLOAD_BITS-1:0] payload,
    output logic                    busy,
    output logic                    done,
    output logic                    complete,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic [7:0]              mem_rd_data,
    output logic                    mem_wr_en,
    output logic [ADDR_W-1:0]       mem_wr_addr,
    output logic [7:0]              mem_wr_data,
    output logic [CNT_W-1:0]        embed_cnt,
    output logic [ADDR_W-1:0]       skip_cnt
);

    localparam int                PAIRS     = num_pairs(WIDTH, HEIGHT);
    localparam logic [ADDR_W-2:0] LAST_PAIR = (ADDR_W-1)'(PAIRS - 1);
    localparam logic [CNT_W-1:0]  BITS_END  = CNT_W'(PAYLOAD_BITS);

    state_t                  state, state_next;
    logic [ADDR_W-2:0]       k;
    logic [CNT_W-1:0]        bit_idx;
    logic [PAYLOAD_BITS-1:0] payload_q;
    logic [7:0]              p0_q, new_p0_q, new_p1_q;
    logic [7:0]              calc_p0, calc_p1;
    logic                    cur_bit, embeddable, frame_end;

    assign cur_bit   = |(payload_q & (PAYLOAD_BITS'(1) << bit_idx));
    assign frame_end = (bit_idx == BITS_END) || (k == LAST_PAIR);

    // p1 is consumed straight off the read bus in CALC, one cycle after its strobe
    de_pair_calc u_calc (
        .p0         (p0_q),
        .p1         (mem_rd_data),
        .b          (cur_bit),
        .new_p0     (calc_p0),
        .new_p1     (calc_p1),
        .embeddable (embeddable)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD0;
            RD0:     state_next = RD1;
            RD1:     state_next = CALC;
            CALC:    state_next = embeddable ? WR0 : NEXT;
            WR0:     state_next = WR1;
            WR1:     state_next = NEXT;
            NEXT:    state_next = frame_end ? DONE : RD0;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state)
            RD0: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = {k, 1'b0};
            end
            RD1: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = {k, 1'b1};
            end
            WR0: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = {k, 1'b0};
                mem_wr_data = new_p0_q;
            end
            WR1: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = {k, 1'b1};
                mem_wr_data = new_p1_q;
            end
            default: ;
        endcase
    end

    // A rejected pair consumes no bit, so the same bit is retried on the next pair
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            k         <= '0;
            bit_idx   <= '0;
            embed_cnt <= '0;
            skip_cnt  <= '0;
            complete  <= 1'b0;
            payload_q <= '0;
            p0_q      <= '0;
            new_p0_q  <= '0;
            new_p1_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k         <= '0;
                        bit_idx   <= '0;
                        embed_cnt <= '0;
                        skip_cnt  <= '0;
                        complete  <= 1'b0;
                        payload_q <= payload;
                    end
                end
                RD1:  p0_q <= mem_rd_data;
                CALC: begin
                    if (embeddable) begin
                        new_p0_q  <= calc_p0;
                        new_p1_q  <= calc_p1;
                        embed_cnt <= embed_cnt + 1'b1;
                        bit_idx   <= bit_idx + 1'b1;
                    end else begin
                        skip_cnt  <= skip_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    k <= k + 1'b1;
                    if (frame_end) complete <= (bit_idx == BITS_END);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/watermark_embed_ctrl.md
# watermark_embed_ctrl

Sequencer for reversible difference-expansion watermark embedding on the red channel. It walks the image memory in horizontal pixel pairs and reads each pair. It decides whether the pair can carry a payload bit, writes the expanded pair back, and stops when the payload is exhausted or the image ends. It sits between the frame memory (8-bit red samples, one per pixel index) and the image-read/stream path, and runs before streaming starts.

## Interface
Parameters:
- WIDTH, 8, image width in pixels (even)
- HEIGHT, 8, image height in pixels
- PAYLOAD_BITS, 8, number of watermark bits per frame
- ADDR_W, 6, pixel-address width (≥ clog2(WIDTH*HEIGHT))

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset; synchronous, active-high
- start  in  1  begin embedding; sampled only in IDLE
- payload  in  PAYLOAD_BITS  watermark; bit 0 embedded first; latched on accepted start
- busy  out  1  high from the cycle after accepted start through the DONE state
- done  out  1  one-cycle pulse at end of frame
- complete  out  1  valid with done and held until next start; 1 = all PAYLOAD_BITS embedded
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  pixel index
- mem_rd_data  in  8  red sample; valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  pixel index
- mem_wr_data  out  8  new red sample
- embed_cnt  out  clog2(PAYLOAD_BITS+1)  bits embedded so far
- skip_cnt  out  ADDR_W  pairs rejected so far

## Operation
FSM states and transitions:
- IDLE → RD0 on start.
- RD0: read address 2k. → RD1.
- RD1: read address 2k+1 and capture p0. → CALC.
- CALC: capture p1 from mem_rd_data and compute. Embeddable → WR0; otherwise → NEXT.
- WR0: write the new p0. → WR1.
- WR1: write the new p1. → NEXT.
- NEXT: k+1. If the bit index equals PAYLOAD_BITS or k equals WIDTH*HEIGHT/2−1 → DONE; else → RD0.
- DONE: done = 1. → IDLE.

Pair k covers pixel indices 2k and 2k+1. Pairs never straddle rows because WIDTH is even.

Arithmetic, with all intermediates 10 bits unsigned and b = payload[bit_idx]:
- hi = max(p0,p1), lo = min(p0,p1), d = hi − lo.
- avg = (p0+p1)>>1.
- h = 2d + b.
- up = avg + ((h+1)>>1), dn = avg − (h>>1).

Embeddable when all of the following hold:
- d ≠ 0
- up ≤ 255
- (h>>1) ≤ avg

When embeddable:
- The position that held hi receives up; the other position receives dn.
- embed_cnt and bit_idx increment in CALC.

When not embeddable:
- Nothing is written.
- No bit is consumed.
- skip_cnt increments.

Start handling and counters:
- Accepted start clears k, bit_idx, embed_cnt, skip_cnt and complete.
- start in any non-IDLE state is ignored.
- complete = (bit_idx == PAYLOAD_BITS), registered in DONE.

## Timing
- Reset values: every output is 0; state = IDLE; all internal counters are 0.
- Reset during any state: the next cycle is IDLE and no strobes are asserted. Memory contents already written stay modified.
- start sampled high in cycle 0 → busy and mem_rd_en (addr 0) both high in cycle 1.
- Pair cost: 6 cycles if embeddable, 4 cycles if skipped.
- done is asserted for exactly 1 cycle; busy falls in the cycle after done.
- Read and write strobes are never asserted in the same cycle.
- Strobes are single-cycle; address and data are stable during the strobe.
- If the last pair's CALC embeds the final bit, both termination conditions hold; this produces one DONE.

## Structure
- Package watermark_pkg holds:
  - state enum (IDLE, RD0, RD1, CALC, WR0, WR1, NEXT, DONE)
  - NUM_PAIRS = WIDTH*HEIGHT/2
  - PIX_MAX = 255
- Sub-module de_pair_calc: purely combinational.
  - Inputs: p0, p1, b.
  - Outputs: new_p0, new_p1, embeddable.
  - Reusable by the extraction path.
- The FSM, counters and memory-port registers live in watermark_embed_ctrl.

## Test plan
- Pair 0 = (100,98), payload bit0 = 1 → writes addr0 = 102 and addr1 = 97; embed_cnt = 1; 6 cycles to RD0 of pair 1.
- Pair 0 = (98,100), bit = 0 → addr0 = 97, addr1 = 101.
- Each of the following is rejected with no write, skip_cnt +1, and the same bit retried on the next pair:
  - (50,50): d = 0
  - (254,240): up = 261
  - (10,0): h>>1 = 10 > avg = 5
- PAYLOAD_BITS = 8 on an image with all pairs embeddable:
  - done is asserted after pair 7.
  - complete = 1.
  - Exactly 16 writes occur.
  - Pixels 16+ are untouched.
- Every pair is (0,0):
  - done comes after 32 pairs × 4 cycles plus overhead.
  - complete = 0, skip_cnt = 32, no writes.
- HRESET asserted in WR0 → next cycle is IDLE with all outputs 0 and no mem_wr_en. A start during busy is ignored, and a new start after reset restarts at addr 0.
